// File: rtl/pe_stripe_feeder.sv
// Sequencer for a PE_NUM-wide systolic array: buffers genes A/B, loads B stripes and streams A.
// Optional per-stripe timeout is compiled in when GENE_FEEDER_TIMEOUT_EN is defined.
module pe_stripe_feeder #(
    parameter int unsigned LEN_A  = 1024,
    parameter int unsigned LEN_B  = 1024,
    parameter int unsigned PE_NUM = 64,
    parameter int unsigned TO_LIM = 2048
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr_en,
    input  logic                    i_wr_sel,
    input  logic [9:0]              i_wr_addr,
    input  logic [1:0]              i_wr_base,
    input  logic                    i_go,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_timeout,
    output logic [3:0]              o_stripe_idx,
    output logic                    o_pe_start,
    output logic [1:0]              o_pe_A,
    output logic [2*PE_NUM-1:0]     o_pe_B,
    input  logic                    i_pe_stripe_end,
    input  logic [9:0]              i_pe_start_position,
    input  logic [9:0]              i_pe_end_position,
    output logic [10:0]             o_abs_end_pos,
    output logic                    o_abs_end_vld
);

    localparam int unsigned NUM_STRIPES = LEN_B / PE_NUM;
    localparam int unsigned AW          = $clog2(LEN_A);
    localparam int unsigned BW          = $clog2(LEN_B);
    localparam logic [10:0] LEN_A_W     = 11'(LEN_A);
    localparam logic [10:0] LAST_A      = 11'(LEN_A - 1);
    localparam logic [3:0]  LAST_STRIPE = 4'(NUM_STRIPES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StGap,
        StStream,
        StNext,
        StDone
    } state_e;

    logic [1:0] mem_a [LEN_A];
    logic [1:0] mem_b [LEN_B];

    state_e              state_q, state_d;
    logic [10:0]         base_q, base_d;
    logic [3:0]          stripe_q, stripe_d;
    logic [10:0]         j_q, j_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pe_start_q, pe_start_d;
    logic [1:0]          pe_a_q, pe_a_d;
    logic [2*PE_NUM-1:0] pe_b_q, pe_b_d;
    logic [10:0]         abs_pos_q, abs_pos_d;
    logic                abs_vld_q, abs_vld_d;
    logic [2*PE_NUM-1:0] b_slice;
    logic [10:0]         next_base;

`ifdef GENE_FEEDER_TIMEOUT_EN
    localparam int unsigned TO_W    = $clog2(TO_LIM);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIM - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;
`endif

    // Buffers have no reset and are frozen for the whole run.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && !busy_q) begin
            if (i_wr_sel) begin
                mem_b[i_wr_addr] <= i_wr_base;
            end else begin
                mem_a[i_wr_addr] <= i_wr_base;
            end
        end
    end

    always_comb begin
        b_slice = '0;
        for (int unsigned n = 0; n < PE_NUM; n++) begin
            b_slice[2*n +: 2] = mem_b[BW'(stripe_q * PE_NUM + n)];
        end
    end

    assign next_base = base_q + {1'b0, i_pe_start_position};

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        stripe_d   = stripe_q;
        j_d        = j_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pe_start_d = 1'b0;
        pe_a_d     = 2'b00;
        pe_b_d     = pe_b_q;
        abs_pos_d  = abs_pos_q;
        abs_vld_d  = 1'b0;
`ifdef GENE_FEEDER_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        timeout_d  = timeout_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (i_go) begin
                    base_d   = '0;
                    stripe_d = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    state_d  = StLoad;
`ifdef GENE_FEEDER_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            StLoad: begin
                pe_b_d  = b_slice;
                j_d     = base_q;
                state_d = StGap;
`ifdef GENE_FEEDER_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            StGap: begin
                state_d = StStream;
            end
            StStream: begin
                if (i_pe_stripe_end) begin
                    abs_pos_d = {1'b0, i_pe_end_position} + base_q;
                    abs_vld_d = 1'b1;
                    state_d   = StNext;
                end else begin
                    pe_start_d = (j_q < LEN_A_W);
                    if (j_q < LEN_A_W) begin
                        pe_a_d = mem_a[j_q[AW-1:0]];
                    end
                    if (j_q != 11'h7ff) begin
                        j_d = j_q + 11'd1;
                    end
`ifdef GENE_FEEDER_TIMEOUT_EN
                    if (to_cnt_q == TO_LAST) begin
                        pe_start_d = 1'b0;
                        pe_a_d     = 2'b00;
                        timeout_d  = 1'b1;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = StDone;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
`endif
                end
            end
            StNext: begin
                base_d = (next_base > LAST_A) ? LAST_A : next_base;
                if (stripe_q == LAST_STRIPE) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    stripe_d = stripe_q + 4'd1;
                    state_d  = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            base_q     <= '0;
            stripe_q   <= '0;
            j_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pe_start_q <= 1'b0;
            pe_a_q     <= '0;
            pe_b_q     <= '0;
            abs_pos_q  <= '0;
            abs_vld_q  <= 1'b0;
`ifdef GENE_FEEDER_TIMEOUT_EN
            to_cnt_q   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            stripe_q   <= stripe_d;
            j_q        <= j_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pe_start_q <= pe_start_d;
            pe_a_q     <= pe_a_d;
            pe_b_q     <= pe_b_d;
            abs_pos_q  <= abs_pos_d;
            abs_vld_q  <= abs_vld_d;
`ifdef GENE_FEEDER_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_stripe_idx  = stripe_q;
    assign o_pe_start    = pe_start_q;
    assign o_pe_A        = pe_a_q;
    assign o_pe_B        = pe_b_q;
    assign o_abs_end_pos = abs_pos_q;
    assign o_abs_end_vld = abs_vld_q;
`ifdef GENE_FEEDER_TIMEOUT_EN
    assign o_timeout     = timeout_q;
`else
    assign o_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_pe_stripe_feeder.sv
// Scoreboard bench for pe_stripe_feeder: the bench plays the PE array and predicts the stream.
// Honours GENE_FEEDER_TIMEOUT_EN to pick the expected timeout behaviour.
module tb_pe_stripe_feeder;

    localparam int LEN_A  = 1024;
    localparam int LEN_B  = 1024;
    localparam int PE_NUM = 64;
    localparam int NSTR   = LEN_B / PE_NUM;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en, wr_sel, go;
    logic [9:0]   wr_addr;
    logic [1:0]   wr_base;
    logic         busy, done, timeout;
    logic [3:0]   stripe_idx;
    logic         pe_start;
    logic [1:0]   pe_a;
    logic [127:0] pe_b;
    logic         stripe_end;
    logic [9:0]   sp_in, ep_in;
    logic [10:0]  abs_pos;
    logic         abs_vld;

    logic [1:0]   a_mem [LEN_A];
    logic [1:0]   b_mem [LEN_B];
    logic [1:0]   exp_a [$];
    logic [127:0] exp_b [$];
    logic [3:0]   exp_idx [$];
    logic [10:0]  exp_end [$];

    int total = 0;
    int bad = 0;
    int end_pulses = 0;

    pe_stripe_feeder dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_wr_en             (wr_en),
        .i_wr_sel            (wr_sel),
        .i_wr_addr           (wr_addr),
        .i_wr_base           (wr_base),
        .i_go                (go),
        .o_busy              (busy),
        .o_done              (done),
        .o_timeout           (timeout),
        .o_stripe_idx        (stripe_idx),
        .o_pe_start          (pe_start),
        .o_pe_A              (pe_a),
        .o_pe_B              (pe_b),
        .i_pe_stripe_end     (stripe_end),
        .i_pe_start_position (sp_in),
        .i_pe_end_position   (ep_in),
        .o_abs_end_pos       (abs_pos),
        .o_abs_end_vld       (abs_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents data or an end position.
    initial begin
        logic prev_start;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (pe_start) begin
                if (exp_a.size() == 0) chk("unexpected pe_start", 128'(pe_start), 128'(0));
                else chk("pe_A", 128'(pe_a), 128'(exp_a.pop_front()));
                if (!prev_start) begin
                    if (exp_b.size() == 0) chk("unexpected stripe", 128'(pe_start), 128'(0));
                    else begin
                        chk("pe_B", pe_b, exp_b.pop_front());
                        chk("stripe_idx", 128'(stripe_idx), 128'(exp_idx.pop_front()));
                    end
                end
            end else begin
                chk("pe_A idle", 128'(pe_a), 128'(0));
            end
            if (abs_vld) begin
                end_pulses++;
                if (exp_end.size() == 0) chk("unexpected abs_end_vld", 128'(abs_vld), 128'(0));
                else chk("abs_end_pos", 128'(abs_pos), 128'(exp_end.pop_front()));
            end
            prev_start = pe_start;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [127:0] stripe_b(input int s);
        logic [127:0] v;
        v = '0;
        for (int n = 0; n < PE_NUM; n++) v[2*n +: 2] = b_mem[s*PE_NUM + n];
        return v;
    endfunction

    task automatic flush();
        exp_a.delete();
        exp_b.delete();
        exp_idx.delete();
        exp_end.delete();
    endtask

    task automatic wr(input logic sel, input int addr, input logic [1:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 10'(addr);
        wr_base = b;
        if (sel) b_mem[addr] = b;
        else a_mem[addr] = b;
    endtask

    task automatic noise();
        wr_en   = 1'($urandom);
        wr_sel  = 1'($urandom);
        wr_addr = 10'($urandom);
        wr_base = 2'($urandom);
        go      = ($urandom_range(0, 15) == 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, 128'(busy), 128'(0));
        chk({tag, " done"}, 128'(done), 128'(0));
        chk({tag, " timeout"}, 128'(timeout), 128'(0));
        chk({tag, " stripe_idx"}, 128'(stripe_idx), 128'(0));
        chk({tag, " pe_start"}, 128'(pe_start), 128'(0));
        chk({tag, " pe_A"}, 128'(pe_a), 128'(0));
        chk({tag, " pe_B"}, pe_b, 128'(0));
        chk({tag, " abs_end_pos"}, 128'(abs_pos), 128'(0));
        chk({tag, " abs_end_vld"}, 128'(abs_vld), 128'(0));
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_idle({tag, " during"});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle({tag, " after"});
        flush();
    endtask

    // Reference model: predicts every stripe from the buffer contents and the PE responses.
    task automatic plan_and_run(input bit directed);
        int base, avail, cnt, wd, h;
        int sp [NSTR];
        int ep [NSTR];
        int n [NSTR];
        int dr [NSTR];
        bit aborted;
        base = 0;
        aborted = 0;
        for (int s = 0; s < NSTR; s++) begin
            sp[s] = $urandom_range(0, 150);
            ep[s] = $urandom_range(0, 1023);
            if (directed && s == 0) begin sp[s] = 100; ep[s] = 300; end
            if (directed && s == 1) begin sp[s] = 900; ep[s] = 50; end
            if (directed && s == 2) sp[s] = 900;
            avail = LEN_A - base;
            n[s] = $urandom_range(1, (avail < 24) ? avail : 24);
            if (avail <= 24 && $urandom_range(0, 1) == 1) n[s] = avail;
            dr[s] = (n[s] == avail) ? $urandom_range(0, 3) : 0;
            exp_idx.push_back(4'(s));
            exp_b.push_back(stripe_b(s));
            for (int i = 0; i < n[s]; i++) exp_a.push_back(a_mem[base + i]);
            exp_end.push_back(11'(ep[s] + base));
            base = base + sp[s];
            if (base > LEN_A - 1) base = LEN_A - 1;
        end
        end_pulses = 0;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("busy after go", 128'(busy), 128'(1));
        chk("done after go", 128'(done), 128'(0));
        for (int s = 0; s < NSTR && !aborted; s++) begin
            cnt = 0;
            wd = 0;
            while (cnt < n[s] && wd < 3000) begin
                @(negedge clk);
                noise();
                if (pe_start) cnt++;
                wd++;
            end
            wr_en = 1'b0;
            go = 1'b0;
            if (cnt < n[s]) begin
                chk("stripe pulse count", 128'(cnt), 128'(n[s]));
                aborted = 1;
            end else begin
                repeat (dr[s]) @(negedge clk);
                stripe_end = 1'b1;
                sp_in = 10'(sp[s]);
                ep_in = 10'(ep[s]);
                h = ($urandom_range(0, 1) == 1) ? 3 : 1;
                for (int c = 1; c <= 3; c++) begin
                    @(negedge clk);
                    if (c >= h) stripe_end = 1'b0;
                end
                sp_in = 10'($urandom);
                ep_in = 10'($urandom);
            end
        end
        wd = 0;
        while (!done && wd < 50) begin
            @(negedge clk);
            wd++;
        end
        chk("run done", 128'(done), 128'(1));
        chk("run busy", 128'(busy), 128'(0));
        chk("run timeout", 128'(timeout), 128'(0));
        chk("run final stripe_idx", 128'(stripe_idx), 128'(NSTR - 1));
        chk("run end pulses", 128'(end_pulses), 128'(NSTR));
        chk("run A left", 128'(exp_a.size()), 128'(0));
        chk("run ends left", 128'(exp_end.size()), 128'(0));
        if (aborted) reset_pulse("recover");
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_base = '0; go = 1'b0;
        stripe_end = 1'b0; sp_in = '0; ep_in = '0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("idle");

        // A all ones, B base n = n%4, no stripe end from the array.
        for (int i = 0; i < LEN_A; i++) wr(1'b0, i, 2'd1);
        for (int i = 0; i < LEN_B; i++) wr(1'b1, i, 2'(i % 4));
        @(negedge clk);
        wr_en = 1'b0;
        exp_idx.push_back(4'd0);
        exp_b.push_back(stripe_b(0));
        for (int i = 0; i < LEN_A; i++) exp_a.push_back(a_mem[i]);
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (2049) @(negedge clk);
        chk("all A streamed", 128'(exp_a.size()), 128'(0));
        chk("not done before limit", 128'(done), 128'(0));
        @(negedge clk);
`ifdef GENE_FEEDER_TIMEOUT_EN
        chk("timeout flag", 128'(timeout), 128'(1));
        chk("timeout done", 128'(done), 128'(1));
        chk("timeout busy", 128'(busy), 128'(0));
`else
        chk("no timeout flag", 128'(timeout), 128'(0));
        chk("still streaming busy", 128'(busy), 128'(1));
        chk("still streaming done", 128'(done), 128'(0));
`endif
        reset_pulse("reset after long stripe");

        // Reset early in a stripe, while A is still being streamed.
        exp_idx.push_back(4'd0);
        exp_b.push_back(stripe_b(0));
        for (int i = 0; i < LEN_A; i++) exp_a.push_back(a_mem[i]);
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (20) @(negedge clk);
        chk("streaming before reset", 128'(pe_start), 128'(1));
        reset_pulse("mid-stream reset");

        for (int i = 0; i < LEN_A; i++) wr(1'b0, i, 2'($urandom));
        for (int i = 0; i < LEN_B; i++) wr(1'b1, i, 2'($urandom));
        @(negedge clk);
        wr_en = 1'b0;
        plan_and_run(1'b1);
        plan_and_run(1'b0);
        plan_and_run(1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
